// File: rtl/registrador_universal.sv
// Parametrised multi-mode register: hold, load, inc/dec (wrapping or saturating),
// shift and rotate, with a registered carry/borrow/shifted-out flag.
module registrador_universal #(
    parameter int          WIDTH       = 16,
    parameter logic [63:0] RESET_VALUE = 64'd0,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROTL = 3'b110;
    localparam logic [2:0] OP_ROTR = 3'b111;

    localparam logic [WIDTH-1:0] RV_W   = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_0  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_1  = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_r;
    logic             carry_r;
    logic [WIDTH-1:0] next_out_s;
    logic             next_carry_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;

    // Extended-width add/subtract: the top bit is the carry or borrow.
    assign inc_s = {1'b0, out_r} + ONE_X;
    assign dec_s = {1'b0, out_r} - ONE_X;

    // Next-state selection for every operation code.
    always_comb begin
        next_out_s   = out_r;
        next_carry_s = carry_r;
        case (op)
            OP_HOLD: begin
                next_out_s   = out_r;
                next_carry_s = carry_r;
            end
            OP_LOAD: begin
                next_out_s   = in;
                next_carry_s = 1'b0;
            end
            OP_INC: begin
                next_carry_s = inc_s[WIDTH];
                if (SATURATE && inc_s[WIDTH]) begin
                    next_out_s = ALL_1;
                end else begin
                    next_out_s = inc_s[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                next_carry_s = dec_s[WIDTH];
                if (SATURATE && dec_s[WIDTH]) begin
                    next_out_s = ALL_0;
                end else begin
                    next_out_s = dec_s[WIDTH-1:0];
                end
            end
            OP_SHL: begin
                next_out_s   = {out_r[WIDTH-2:0], serial_in};
                next_carry_s = out_r[WIDTH-1];
            end
            OP_SHR: begin
                next_out_s   = {serial_in, out_r[WIDTH-1:1]};
                next_carry_s = out_r[0];
            end
            OP_ROTL: begin
                next_out_s   = {out_r[WIDTH-2:0], out_r[WIDTH-1]};
                next_carry_s = out_r[WIDTH-1];
            end
            OP_ROTR: begin
                next_out_s   = {out_r[0], out_r[WIDTH-1:1]};
                next_carry_s = out_r[0];
            end
            default: begin
                next_out_s   = out_r;
                next_carry_s = carry_r;
            end
        endcase
    end

    // State register; reset wins over any pending operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_r   <= RV_W;
            carry_r <= 1'b0;
        end else begin
            out_r   <= next_out_s;
            carry_r <= next_carry_s;
        end
    end

    assign out   = out_r;
    assign carry = carry_r;
    assign zero  = (out_r == ALL_0);

endmodule

// File: tb/tb_registrador_universal.sv
// Bench for registrador_universal: directed table on 16-bit instances, short
// width-2 sequence, then random regression of six configurations against a model.
module tb_registrador_universal;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] in_v = 64'd0;
    logic        serial_in = 1'b0;

    logic [15:0] o0, o1;
    logic [1:0]  o2, o3;
    logic [32:0] o4, o5;
    logic [5:0]  dcar, dzero;
    logic [63:0] dout [6];

    int checks = 0;
    int errors = 0;

    int          cw  [6];
    bit          cs  [6];
    logic [63:0] crv [6];
    logic [63:0] m_out [6];
    logic        m_car [6];

    always #5 clock = ~clock;

    registrador_universal #(.WIDTH(16), .RESET_VALUE(64'h0100), .SATURATE(1'b0)) u0 (
        .clock(clock), .reset(reset), .in(in_v[15:0]), .op(op), .serial_in(serial_in),
        .out(o0), .carry(dcar[0]), .zero(dzero[0]));
    registrador_universal #(.WIDTH(16), .RESET_VALUE(64'h0000), .SATURATE(1'b1)) u1 (
        .clock(clock), .reset(reset), .in(in_v[15:0]), .op(op), .serial_in(serial_in),
        .out(o1), .carry(dcar[1]), .zero(dzero[1]));
    registrador_universal #(.WIDTH(2), .RESET_VALUE(64'h2), .SATURATE(1'b0)) u2 (
        .clock(clock), .reset(reset), .in(in_v[1:0]), .op(op), .serial_in(serial_in),
        .out(o2), .carry(dcar[2]), .zero(dzero[2]));
    registrador_universal #(.WIDTH(2), .RESET_VALUE(64'h1), .SATURATE(1'b1)) u3 (
        .clock(clock), .reset(reset), .in(in_v[1:0]), .op(op), .serial_in(serial_in),
        .out(o3), .carry(dcar[3]), .zero(dzero[3]));
    registrador_universal #(.WIDTH(33), .RESET_VALUE(64'h1_0000_0001), .SATURATE(1'b0)) u4 (
        .clock(clock), .reset(reset), .in(in_v[32:0]), .op(op), .serial_in(serial_in),
        .out(o4), .carry(dcar[4]), .zero(dzero[4]));
    registrador_universal #(.WIDTH(33), .RESET_VALUE(64'h1_FFFF_FFFF), .SATURATE(1'b1)) u5 (
        .clock(clock), .reset(reset), .in(in_v[32:0]), .op(op), .serial_in(serial_in),
        .out(o5), .carry(dcar[5]), .zero(dzero[5]));

    assign dout[0] = 64'(o0);
    assign dout[1] = 64'(o1);
    assign dout[2] = 64'(o2);
    assign dout[3] = 64'(o3);
    assign dout[4] = 64'(o4);
    assign dout[5] = 64'(o5);

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic [15:0] din;
        logic        si;
        logic [15:0] e0;
        logic        c0;
        logic [15:0] e1;
        logic        c1;
    } vec_t;

    vec_t vt [25];

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference behaviour computed from the operation rules with plain arithmetic.
    function automatic void model_step(int k);
        int          w;
        logic [63:0] mask, o, sum;
        logic        c, msb, lsb;
        w    = cw[k];
        mask = (64'd1 << w) - 64'd1;
        o    = m_out[k];
        c    = m_car[k];
        msb  = o[w-1];
        lsb  = o[0];
        if (reset) begin
            o = crv[k] & mask;
            c = 1'b0;
        end else begin
            case (op)
                3'd1: begin o = in_v & mask; c = 1'b0; end
                3'd2: begin
                    sum = o + 64'd1;
                    c   = (sum > mask);
                    o   = (cs[k] && c) ? mask : (sum & mask);
                end
                3'd3: begin
                    c = (o == 64'd0);
                    o = (cs[k] && c) ? 64'd0 : ((o - 64'd1) & mask);
                end
                3'd4: begin c = msb; o = ((o << 1) | 64'(serial_in)) & mask; end
                3'd5: begin c = lsb; o = (o >> 1) | (64'(serial_in) << (w - 1)); end
                3'd6: begin c = msb; o = ((o << 1) | 64'(msb)) & mask; end
                3'd7: begin c = lsb; o = (o >> 1) | (64'(lsb) << (w - 1)); end
                default: ;
            endcase
        end
        m_out[k] = o;
        m_car[k] = c;
    endfunction

    task automatic step(input logic r, input logic [2:0] o, input logic [63:0] d, input logic s);
        reset = r; op = o; in_v = d; serial_in = s;
        @(posedge clock);
        for (int k = 0; k < 6; k++) model_step(k);
        #1;
    endtask

    initial begin
        cw  = '{16, 16, 2, 2, 33, 33};
        cs  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        crv = '{64'h0100, 64'h0, 64'h2, 64'h1, 64'h1_0000_0001, 64'h1_FFFF_FFFF};
        for (int k = 0; k < 6; k++) begin
            m_out[k] = 64'd0;
            m_car[k] = 1'b0;
        end

        //        rst   op    din       si    u0 out    c     u1 out    c
        vt[0]  = '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 3'd2, 16'h0000, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0};
        vt[2]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0101, 1'b0, 16'h0001, 1'b0};
        vt[3]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0102, 1'b0, 16'h0002, 1'b0};
        vt[4]  = '{1'b0, 3'd1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vt[5]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        vt[6]  = '{1'b0, 3'd3, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'hFFFE, 1'b0};
        vt[7]  = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
        vt[8]  = '{1'b0, 3'd0, 16'h5555, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 1'b0};
        vt[9]  = '{1'b0, 3'd1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0};
        vt[10] = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vt[11] = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        vt[12] = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vt[13] = '{1'b0, 3'd1, 16'h0001, 1'b0, 16'h0001, 1'b0, 16'h0001, 1'b0};
        vt[14] = '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[15] = '{1'b0, 3'd3, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        vt[16] = '{1'b0, 3'd1, 16'h8001, 1'b0, 16'h8001, 1'b0, 16'h8001, 1'b0};
        vt[17] = '{1'b0, 3'd4, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0002, 1'b1};
        vt[18] = '{1'b0, 3'd5, 16'h0000, 1'b1, 16'h8001, 1'b0, 16'h8001, 1'b0};
        vt[19] = '{1'b0, 3'd7, 16'h0000, 1'b0, 16'hC000, 1'b1, 16'hC000, 1'b1};
        vt[20] = '{1'b0, 3'd6, 16'h0000, 1'b0, 16'h8001, 1'b1, 16'h8001, 1'b1};
        vt[21] = '{1'b0, 3'd1, 16'h0010, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0};
        vt[22] = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0011, 1'b0, 16'h0011, 1'b0};
        vt[23] = '{1'b1, 3'd1, 16'h1234, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0};
        vt[24] = '{1'b0, 3'd2, 16'h0000, 1'b0, 16'h0101, 1'b0, 16'h0001, 1'b0};

        for (int i = 0; i < 25; i++) begin
            step(vt[i].rst, vt[i].op, 64'(vt[i].din), vt[i].si);
            check("u0_out",  i, dout[0], 64'(vt[i].e0));
            check("u0_cy",   i, 64'(dcar[0]), 64'(vt[i].c0));
            check("u0_zero", i, 64'(dzero[0]), 64'(vt[i].e0 == 16'h0000));
            check("u1_out",  i, dout[1], 64'(vt[i].e1));
            check("u1_cy",   i, 64'(dcar[1]), 64'(vt[i].c1));
            check("u1_zero", i, 64'(dzero[1]), 64'(vt[i].e1 == 16'h0000));
        end

        // Width-2 corner: wrap versus saturate from their reset values.
        step(1'b1, 3'd0, 64'd0, 1'b0);
        check("w2_rst", 0, dout[2], 64'd2);
        check("w2s_rst", 0, dout[3], 64'd1);
        step(1'b0, 3'd2, 64'd0, 1'b0);
        check("w2_inc", 1, {dout[2][62:0], dcar[2]}, 64'd6);
        check("w2s_inc", 1, {dout[3][62:0], dcar[3]}, 64'd4);
        step(1'b0, 3'd2, 64'd0, 1'b0);
        check("w2_inc", 2, {dout[2][62:0], dcar[2]}, 64'd1);
        check("w2s_inc", 2, {dout[3][62:0], dcar[3]}, 64'd6);
        step(1'b0, 3'd2, 64'd0, 1'b0);
        check("w2_inc", 3, {dout[2][62:0], dcar[2]}, 64'd2);
        check("w2s_inc", 3, {dout[3][62:0], dcar[3]}, 64'd7);
        check("w2_zero", 3, 64'(dzero[2]), 64'd0);

        // Random regression, all configurations every cycle.
        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(31) == 0), 3'($urandom_range(7)),
                 {32'($urandom), 32'($urandom)}, 1'($urandom_range(1)));
            for (int k = 0; k < 6; k++) begin
                check("rnd_out",  k, dout[k], m_out[k]);
                check("rnd_cy",   k, 64'(dcar[k]), 64'(m_car[k]));
                check("rnd_zero", k, 64'(dzero[k]), 64'(m_out[k] == 64'd0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
